// File: rtl/seq_divider_32_bit_if.sv
// Request/result bundle between a requester and seq_divider_32_bit.
// signed_op exists only when SIGNED_DIV_EN is defined.
interface seq_divider_32_bit_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef SIGNED_DIV_EN
  logic        signed_op;
`endif
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
`ifdef SIGNED_DIV_EN
    output signed_op,
`endif
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
`ifdef SIGNED_DIV_EN
    input  signed_op,
`endif
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_32_bit.sv
// Multi-cycle restoring divider, one quotient bit per clock, using the shared external adder.
// Define SIGNED_DIV_EN to add signed_op (magnitude divide with sign fix-up at result latch).
module seq_divider_32_bit #(
  parameter int ITER = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_divider_32_bit_if.slave  dv,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_cin,
  input  logic [31:0]          add_sum,
  input  logic                 add_cout
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, DZERO, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      q_reg, r_reg, d_reg;
  logic [31:0]      trial, q_nxt, r_nxt;
  logic             take, accept, last;
  logic             neg_dvd, neg_dvs, neg_q, neg_r;

  function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

`ifdef SIGNED_DIV_EN
  assign neg_dvd = dv.signed_op & dv.dividend[31];
  assign neg_dvs = dv.signed_op & dv.divisor[31];
`else
  assign neg_dvd = 1'b0;
  assign neg_dvs = 1'b0;
`endif

  assign accept = dv.start && (state == IDLE || state == DONE);
  assign last   = (cnt == CNT_LAST);

  // A set R[31] means the shifted remainder already exceeds any 32-bit divisor.
  assign trial = {r_reg[30:0], q_reg[31]};
  assign take  = add_cout | r_reg[31];
  assign r_nxt = take ? add_sum : trial;
  assign q_nxt = {q_reg[30:0], take};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (dv.start) state_nxt = (dv.divisor == 32'd0) ? DZERO : RUN;
      RUN:   if (last) state_nxt = DONE;
      DZERO: state_nxt = DONE;
      DONE:  begin
        if (dv.start) state_nxt = (dv.divisor == 32'd0) ? DZERO : RUN;
        else          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dv.busy = 1'b0;
    dv.done = 1'b0;
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_cin = 1'b1;
    case (state)
      RUN: begin
        dv.busy = 1'b1;
        add_a   = trial;
        add_b   = d_reg;
      end
      DZERO: dv.busy = 1'b1;
      DONE:  dv.done = 1'b1;
      default: ;
    endcase
  end

  // Working registers carry no reset; they are always loaded on an accepted start.
  // A zero divisor keeps the raw dividend so it can be returned as the remainder.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_reg <= (dv.divisor == 32'd0) ? dv.dividend : negate_if(neg_dvd, dv.dividend);
      r_reg <= 32'd0;
      d_reg <= negate_if(neg_dvs, dv.divisor);
    end else if (state == RUN) begin
      q_reg <= q_nxt;
      r_reg <= r_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      dv.quotient    <= 32'd0;
      dv.remainder   <= 32'd0;
      dv.div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      neg_q <= neg_dvd ^ neg_dvs;
      neg_r <= neg_dvd;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (last) begin
        dv.quotient    <= negate_if(neg_q, q_nxt);
        dv.remainder   <= negate_if(neg_r, r_nxt);
        dv.div_by_zero <= 1'b0;
      end
    end else if (state == DZERO) begin
      dv.quotient    <= 32'hFFFF_FFFF;
      dv.remainder   <= q_reg;
      dv.div_by_zero <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_divider_32_bit.sv
// Directed bench for seq_divider_32_bit together with a model of the shared 32-bit adder.
// Signed vectors are included when SIGNED_DIV_EN is defined.
module tb_seq_divider_32_bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [32:0] add_full;
  int          checks;
  int          errors;

  seq_divider_32_bit_if dvif ();

  seq_divider_32_bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dv       (dvif),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Shared ripple adder in subtract mode: a + ~b + cin.
  assign add_full = {1'b0, add_a} + {1'b0, ~add_b} + {32'd0, add_cin};
  assign add_sum  = add_full[31:0];
  assign add_cout = add_full[32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in the low phase; the following rising edge is E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    dvif.start    = 1'b1;
    dvif.dividend = a;
    dvif.divisor  = b;
`ifdef SIGNED_DIV_EN
    dvif.signed_op = s;
`else
    if (s) $display("note: signed_op requested in unsigned build");
`endif
    @(posedge clk);
    #1;
    dvif.start    = 1'b0;
    dvif.dividend = 32'h5A5A_5A5A;
    dvif.divisor  = 32'h0000_0003;
  endtask

  task automatic wait_done(input string tag, output int edges);
    bit seen;
    seen  = 0;
    edges = 0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (dvif.done) seen = 1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat);
    int lat;
    @(negedge clk);
    start_op(a, b, s);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(dvif.busy), 32'd1);
    wait_done(tag, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_q"}, dvif.quotient, eq);
    chk({tag, "_r"}, dvif.remainder, er);
    chk({tag, "_dz"}, 32'(dvif.div_by_zero), 32'(edz));
    chk({tag, "_busy_done"}, 32'(dvif.busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(dvif.done), 32'd0);
    chk({tag, "_q_hold"}, dvif.quotient, eq);
  endtask

  initial begin
    int lat;
    int done_cnt;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    dvif.start    = 1'b0;
    dvif.dividend = 32'd0;
    dvif.divisor  = 32'd0;
`ifdef SIGNED_DIV_EN
    dvif.signed_op = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(dvif.busy), 32'd0);
    chk("rst_done", 32'(dvif.done), 32'd0);
    chk("rst_q", dvif.quotient, 32'd0);
    chk("rst_r", dvif.remainder, 32'd0);
    chk("rst_dz", 32'(dvif.div_by_zero), 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    rst_n = 1'b1;

    // Adder drive during the first RUN cycle: add_b = captured divisor, add_a = {0, Q[31]}.
    @(negedge clk);
    start_op(32'd100, 32'd7, 1'b0);
    @(negedge clk);
    chk("run_add_b", add_b, 32'd7);
    chk("run_add_a", add_a, 32'd0);
    chk("run_add_cin", 32'(add_cin), 32'd1);
    wait_done("d100_7", lat);
    chk("d100_7_lat", 32'(lat), 32'd32);
    chk("d100_7_q", dvif.quotient, 32'd14);
    chk("d100_7_r", dvif.remainder, 32'd2);
    chk("d100_7_dz", 32'(dvif.div_by_zero), 32'd0);
    chk("idle_add_a", add_a, 32'd0);

    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
    run_div("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 32);
    run_div("dmax_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 1'b0, 32);
    run_div("dzero", 32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1);

    // Start pulsed mid-operation is ignored; start in DONE chains straight into a new op.
    @(negedge clk);
    start_op(32'd50, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dvif.start    = 1'b1;
    dvif.dividend = 32'd9;
    dvif.divisor  = 32'd2;
    @(posedge clk);
    #1;
    dvif.start = 1'b0;
    wait_done("d50_3", lat);
    chk("d50_3_lat", 32'(10 + lat), 32'd32);
    chk("d50_3_q", dvif.quotient, 32'd16);
    chk("d50_3_r", dvif.remainder, 32'd2);
    start_op(32'd1000, 32'd10, 1'b0);
    @(negedge clk);
    chk("b2b_busy", 32'(dvif.busy), 32'd1);
    chk("b2b_done_low", 32'(dvif.done), 32'd0);
    wait_done("b2b", lat);
    chk("b2b_lat", 32'(lat), 32'd32);
    chk("b2b_q", dvif.quotient, 32'd100);
    chk("b2b_r", dvif.remainder, 32'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start_op(32'd200, 32'd3, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(dvif.busy), 32'd0);
    chk("mrst_done", 32'(dvif.done), 32'd0);
    chk("mrst_q", dvif.quotient, 32'd0);
    chk("mrst_r", dvif.remainder, 32'd0);
    chk("mrst_add_a", add_a, 32'd0);
    chk("mrst_add_b", add_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dvif.done) done_cnt++;
    end
    chk("mrst_no_done", 32'(done_cnt), 32'd0);
    run_div("d81_9", 32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0, 32);

`ifdef SIGNED_DIV_EN
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 32);
    run_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 32);
    run_div("s_dzero", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1);
    run_div("s_unsigned", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 32);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
